// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: shared widths, ALU/MD opcode enums, MD state encoding and EX/MEM register layout
package execute_stage_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int MD_ITERATIONS = 32;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_MFHI = 4'd12,
    ALU_MFLO = 4'd13
  } aluControl_e;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } mdControl_e;
  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } mdState_e;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] aluOutput;
    logic [DATA_WIDTH-1:0] registerRt;
    logic                  isAluOutputZero;
    logic                  isBranch;
    logic                  isBneElseBeq;
    logic                  shouldWriteMemory;
    logic                  shouldWriteRegister;
    logic                  isLoad;
    logic [4:0]            destinationRegister;
  } exMem_t;
endpackage

// File: rtl/execute_stage_mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider owning HI/LO (in: start, mdControl, operandA/B; out: busy, hi, lo)
module mult_div_unit
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int MD_CYCLES = MD_ITERATIONS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdControl,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(MD_CYCLES);
  mdState_e state, nextState;
  logic [CW-1:0] count;
  logic [2*WIDTH-1:0] acc, stepAcc, product;
  logic [WIDTH-1:0] other, magA, magB, diff, quot, rem;
  logic [WIDTH:0] shifted, sum;
  logic isDiv, negLo, negHi, divZero, isSigned, isDivOp, signA, signB, ge;
  always_comb begin
    isSigned = mdControl == MD_MULT || mdControl == MD_DIV;
    isDivOp = mdControl == MD_DIV || mdControl == MD_DIVU;
    signA = isSigned & operandA[WIDTH-1];
    signB = isSigned & operandB[WIDTH-1];
    magA = signA ? -operandA : operandA;
    magB = signB ? -operandB : operandB;
  end
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}; the FIX cycle runs the final iteration
  always_comb begin
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge = shifted >= {1'b0, other};
    diff = shifted[WIDTH-1:0] - other;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & other};
    stepAcc = isDiv ? {ge ? diff : shifted[WIDTH-1:0], acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
    product = negLo ? -stepAcc : stepAcc;
    quot = stepAcc[WIDTH-1:0];
    rem = stepAcc[2*WIDTH-1:WIDTH];
  end
  always_comb begin
    nextState = state == MD_IDLE ? (start ? MD_RUN : MD_IDLE) :
                state == MD_RUN  ? (count == '0 ? MD_FIX : MD_RUN) : MD_IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
      other <= '0;
      count <= '0;
      isDiv <= 1'b0;
      negLo <= 1'b0;
      negHi <= 1'b0;
      divZero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (state == MD_IDLE && start) begin
      acc <= {{WIDTH{1'b0}}, magA};
      other <= magB;
      count <= CW'(MD_CYCLES - 2);
      isDiv <= isDivOp;
      negLo <= signA ^ signB;
      negHi <= signA;
      divZero <= isDivOp && operandB == '0;
    end else if (state == MD_RUN) begin
      acc <= stepAcc;
      count <= count - 1'b1;
    end else if (state == MD_FIX) begin
      hi <= isDiv ? (negHi ? -rem : rem) : product[2*WIDTH-1:WIDTH];
      lo <= isDiv ? (divZero ? '1 : negLo ? -quot : quot) : product[WIDTH-1:0];
    end
  end
  assign busy = state != MD_IDLE;
endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage ALU + mult/div host + EX/MEM register (in: id* instruction, operands, flush; out: stall, mdBusy, registered mem*)
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int MD_CYCLES = MD_ITERATIONS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idValid,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [WIDTH-1:0] idRegisterRt,
  input  logic [4:0]       shiftAmount,
  input  logic [3:0]       aluControl,
  input  logic [2:0]       mdControl,
  input  logic             idIsBranch,
  input  logic             idIsBneElseBeq,
  input  logic             idShouldWriteMemory,
  input  logic             idShouldWriteRegister,
  input  logic             idIsLoad,
  input  logic [4:0]       idDestinationRegister,
  input  logic             flush,
  output logic             stall,
  output logic             mdBusy,
  output logic [WIDTH-1:0] memAluOutput,
  output logic [WIDTH-1:0] memRegisterRt,
  output logic             memIsAluOutputZero,
  output logic             memIsBranch,
  output logic             memIsBneElseBeq,
  output logic             memShouldWriteMemory,
  output logic             memShouldWriteRegister,
  output logic             memIsLoad,
  output logic [4:0]       memDestinationRegister
);
  logic [WIDTH-1:0] aluResult, hiValue, loValue;
  logic mdRequest, readsHiLo, mdStart, bubble;
  exMem_t exMem, exMemNext;
  always_comb begin
    aluResult = '0;
    case (aluControl)
      ALU_ADD:  aluResult = operandA + operandB;
      ALU_SUB:  aluResult = operandA - operandB;
      ALU_AND:  aluResult = operandA & operandB;
      ALU_OR:   aluResult = operandA | operandB;
      ALU_XOR:  aluResult = operandA ^ operandB;
      ALU_NOR:  aluResult = ~(operandA | operandB);
      ALU_SLT:  aluResult = {{(WIDTH-1){1'b0}}, $signed(operandA) < $signed(operandB)};
      ALU_SLTU: aluResult = {{(WIDTH-1){1'b0}}, operandA < operandB};
      ALU_SLL:  aluResult = operandB << shiftAmount;
      ALU_SRL:  aluResult = operandB >> shiftAmount;
      ALU_SRA:  aluResult = $signed(operandB) >>> shiftAmount;
      ALU_LUI:  aluResult = {operandB[15:0], {(WIDTH-16){1'b0}}};
      ALU_MFHI: aluResult = hiValue;
      ALU_MFLO: aluResult = loValue;
      default:  aluResult = '0;
    endcase
  end
  always_comb begin
    mdRequest = mdControl != MD_NONE;
    readsHiLo = aluControl == ALU_MFHI || aluControl == ALU_MFLO;
    stall = idValid & mdBusy & (readsHiLo | mdRequest);
    mdStart = idValid & mdRequest & ~flush & ~mdBusy;
    bubble = ~idValid | flush | stall;
  end
  // an MD instruction still flows down the pipe but must not write anything
  always_comb begin
    exMemNext.aluOutput = aluResult;
    exMemNext.registerRt = idRegisterRt;
    exMemNext.isAluOutputZero = aluResult == '0;
    exMemNext.isBranch = idIsBranch;
    exMemNext.isBneElseBeq = idIsBneElseBeq;
    exMemNext.shouldWriteMemory = idShouldWriteMemory & ~mdRequest;
    exMemNext.shouldWriteRegister = idShouldWriteRegister & ~mdRequest;
    exMemNext.isLoad = idIsLoad;
    exMemNext.destinationRegister = idDestinationRegister;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) exMem <= '0;
    else exMem <= bubble ? '0 : exMemNext;
  end
  mult_div_unit #(.WIDTH(WIDTH), .MD_CYCLES(MD_CYCLES)) multDiv (
    .clock(clock),
    .reset(reset),
    .start(mdStart),
    .mdControl(mdControl),
    .operandA(operandA),
    .operandB(operandB),
    .busy(mdBusy),
    .hi(hiValue),
    .lo(loValue)
  );
  assign memAluOutput = exMem.aluOutput;
  assign memRegisterRt = exMem.registerRt;
  assign memIsAluOutputZero = exMem.isAluOutputZero;
  assign memIsBranch = exMem.isBranch;
  assign memIsBneElseBeq = exMem.isBneElseBeq;
  assign memShouldWriteMemory = exMem.shouldWriteMemory;
  assign memShouldWriteRegister = exMem.shouldWriteRegister;
  assign memIsLoad = exMem.isLoad;
  assign memDestinationRegister = exMem.destinationRegister;
endmodule
